// File: rtl/keyed_mux_lock_seq_if.sv
// rtl/keyed_mux_lock_seq_if.sv - key-load handshake and candidate/output bundle for keyed_mux_lock_seq
interface keyed_mux_lock_seq_if #(
  parameter int NCH  = 2,
  parameter int SELW = 2
);
  localparam int NCAND = 1 << SELW;

  logic                 KEY_START;
  logic                 KEY_SI;
  logic                 KEY_VLD;
  logic                 KEY_RDY;
  logic [NCH*NCAND-1:0] CAND_IN;
  logic [NCH-1:0]       MUX_O;
  logic                 ARMED;
  logic                 KEY_ERR;

  modport master (
    output KEY_START, KEY_SI, KEY_VLD, CAND_IN,
    input  KEY_RDY, MUX_O, ARMED, KEY_ERR
  );

  modport slave (
    input  KEY_START, KEY_SI, KEY_VLD, CAND_IN,
    output KEY_RDY, MUX_O, ARMED, KEY_ERR
  );
endinterface

// File: rtl/keyed_mux_lock_seq.sv
// rtl/keyed_mux_lock_seq.sv - serially keyed locking-MUX array; KEYED_MUX_KEY_PARITY_EN adds a trailing even-parity key bit
module keyed_mux_lock_seq #(
  parameter int NCH  = 2,
  parameter int SELW = 2
) (
  input  logic               CK,
  input  logic               RST_N,
  keyed_mux_lock_seq_if.slave bus
);
  localparam int KEY_W = NCH * SELW;
  localparam int NCAND = 1 << SELW;
`ifdef KEYED_MUX_KEY_PARITY_EN
  localparam int NBITS = KEY_W + 1;
`else
  localparam int NBITS = KEY_W;
`endif
  localparam int CNT_W = $clog2(NBITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, ARMED_S} state_t;

  state_t             state_q, state_d;
  logic [NBITS-1:0]   shadow_q;
  logic [KEY_W-1:0]   active_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               armed_q;
  logic               err_q;
  logic [NCH-1:0]     mux_q;
  logic [NCH-1:0]     mux_d;
  logic               key_ok;
  logic               start_ok;
  logic               last_bit;

`ifdef KEYED_MUX_KEY_PARITY_EN
  // Parity bit makes the total count of ones (key plus parity) even.
  assign key_ok = ((^shadow_q[KEY_W-1:0]) == shadow_q[KEY_W]);
`else
  assign key_ok = 1'b1;
`endif

  assign start_ok = bus.KEY_START && (state_q != COMMIT);
  assign last_bit = (cnt_q == CNT_W'(NBITS - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.KEY_START) state_d = SHIFT;
      SHIFT:   if (!bus.KEY_START && bus.KEY_VLD && last_bit) state_d = COMMIT;
      COMMIT:  state_d = key_ok ? ARMED_S : IDLE;
      ARMED_S: if (bus.KEY_START) state_d = SHIFT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      armed_q  <= 1'b0;
      err_q    <= 1'b0;
      mux_q    <= '0;
    end else begin
      state_q <= state_d;
      mux_q   <= armed_q ? mux_d : '0;
      if (start_ok) begin
        cnt_q    <= '0;
        shadow_q <= '0;
        err_q    <= 1'b0;
      end else if (state_q == SHIFT && bus.KEY_VLD) begin
        for (int i = 0; i < NBITS; i++) begin
          if (cnt_q == CNT_W'(i)) shadow_q[i] <= bus.KEY_SI;
        end
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == COMMIT) begin
        if (key_ok) begin
          active_q <= shadow_q[KEY_W-1:0];
          armed_q  <= 1'b1;
        end else begin
          err_q   <= 1'b1;
          armed_q <= 1'b0;
        end
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [SELW-1:0]  sel;
    logic [NCAND-1:0] grp;
    assign sel      = active_q[c*SELW +: SELW];
    assign grp      = bus.CAND_IN[c*NCAND +: NCAND];
    assign mux_d[c] = grp[sel];
  end

  assign bus.KEY_RDY = (state_q == SHIFT);
  assign bus.MUX_O   = mux_q;
  assign bus.ARMED   = armed_q;
  assign bus.KEY_ERR = err_q;
endmodule

// File: tb/tb_keyed_mux_lock_seq.sv
// tb/tb_keyed_mux_lock_seq.sv - directed self-checking bench for keyed_mux_lock_seq
module tb_keyed_mux_lock_seq;
  logic CK;
  logic RST_N;
  int   checks = 0;
  int   errors = 0;

  keyed_mux_lock_seq_if #(.NCH(2), .SELW(2)) bus ();

  keyed_mux_lock_seq #(.NCH(2), .SELW(2)) dut (
    .CK   (CK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  // Pulses KEY_START, then sends n bits LSB first; returns in the COMMIT cycle.
  task automatic load_bits(input logic [7:0] bits, input int n);
    bus.KEY_START = 1'b1;
    tick();
    bus.KEY_START = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.KEY_VLD = 1'b1;
      bus.KEY_SI  = bits[i];
      chk("rdy_shift", 32'(bus.KEY_RDY), 32'd1);
      tick();
    end
    bus.KEY_VLD = 1'b0;
    bus.KEY_SI  = 1'b0;
  endtask

  initial begin
    RST_N         = 1'b0;
    bus.KEY_START = 1'b0;
    bus.KEY_SI    = 1'b0;
    bus.KEY_VLD   = 1'b0;
    bus.CAND_IN   = 8'h00;
    tick();
    tick();
    chk("rst_mux",   32'(bus.MUX_O),   32'd0);
    chk("rst_armed", 32'(bus.ARMED),   32'd0);
    chk("rst_rdy",   32'(bus.KEY_RDY), 32'd0);
    chk("rst_err",   32'(bus.KEY_ERR), 32'd0);
    RST_N = 1'b1;
    tick();

    bus.CAND_IN = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("prekey_mux",   32'(bus.MUX_O), 32'd0);
      chk("prekey_armed", 32'(bus.ARMED), 32'd0);
    end

    // Key 1101: ch0 sel 1, ch1 sel 3.
    load_bits(8'b0000_1101, 4);
    chk("commit_rdy",   32'(bus.KEY_RDY), 32'd0);
    chk("commit_armed", 32'(bus.ARMED),   32'd0);
    bus.CAND_IN = 8'b1000_0010;
    tick();
    chk("armed_rise", 32'(bus.ARMED), 32'd1);
    chk("mux_first0", 32'(bus.MUX_O), 32'd0);
    tick();
    chk("mux_k1101_a", 32'(bus.MUX_O), 32'b11);
    bus.CAND_IN = 8'b0111_1101;
    tick();
    chk("mux_k1101_b", 32'(bus.MUX_O), 32'b00);

    // Re-key to 0000 while old key keeps driving.
    bus.CAND_IN = 8'b0001_0010;
    tick();
    chk("rekey_pre", 32'(bus.MUX_O), 32'b01);
    load_bits(8'b0000_0000, 4);
    chk("rekey_commit",   32'(bus.MUX_O), 32'b01);
    chk("rekey_armed",    32'(bus.ARMED), 32'd1);
    tick();
    chk("rekey_commit1",  32'(bus.MUX_O), 32'b01);
    tick();
    chk("rekey_new",      32'(bus.MUX_O), 32'b10);

    // Restart mid-load, with a stall cycle, then KEY_START during COMMIT.
    bus.KEY_START = 1'b1;
    tick();
    bus.KEY_START = 1'b0;
    bus.KEY_VLD = 1'b1; bus.KEY_SI = 1'b1; tick();
    bus.KEY_VLD = 1'b0; tick();
    chk("stall_rdy", 32'(bus.KEY_RDY), 32'd1);
    bus.KEY_VLD = 1'b1; bus.KEY_SI = 1'b1; tick();
    bus.KEY_START = 1'b1; bus.KEY_VLD = 1'b1; bus.KEY_SI = 1'b1; tick();
    bus.KEY_START = 1'b0;
    chk("restart_rdy", 32'(bus.KEY_RDY), 32'd1);
    for (int i = 0; i < 4; i++) begin
      bus.KEY_VLD = 1'b1;
      bus.KEY_SI  = (i == 1);
      tick();
    end
    bus.KEY_VLD = 1'b0;
    chk("restart_commit_rdy", 32'(bus.KEY_RDY), 32'd0);
    bus.KEY_START = 1'b1;
    tick();
    bus.KEY_START = 1'b0;
    chk("commit_start_ignored", 32'(bus.KEY_RDY), 32'd0);
    // Key 0010: ch0 sel 2, ch1 sel 0.
    bus.CAND_IN = 8'b0001_0100;
    tick();
    chk("mux_k0010_a", 32'(bus.MUX_O), 32'b11);
    bus.CAND_IN = 8'b1110_1011;
    tick();
    chk("mux_k0010_b", 32'(bus.MUX_O), 32'b00);

    // Asynchronous reset mid-SHIFT.
    bus.KEY_START = 1'b1;
    tick();
    bus.KEY_START = 1'b0;
    bus.KEY_VLD = 1'b1; bus.KEY_SI = 1'b1; tick();
    bus.KEY_VLD = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    chk("arst_shift_rdy",   32'(bus.KEY_RDY), 32'd0);
    chk("arst_shift_armed", 32'(bus.ARMED),   32'd0);
    chk("arst_shift_mux",   32'(bus.MUX_O),   32'd0);
    tick();
    RST_N = 1'b1;
    tick();
    chk("post_rst_idle_rdy", 32'(bus.KEY_RDY), 32'd0);
    chk("post_rst_armed",    32'(bus.ARMED),   32'd0);

    // Re-arm with 1101, then asynchronous reset while ARMED.
    bus.CAND_IN = 8'b1000_0010;
    load_bits(8'b0000_1101, 4);
    tick();
    tick();
    chk("rearm_mux", 32'(bus.MUX_O), 32'b11);
    #2 RST_N = 1'b0;
    #1;
    chk("arst_armed_armed", 32'(bus.ARMED),   32'd0);
    chk("arst_armed_mux",   32'(bus.MUX_O),   32'd0);
    chk("arst_armed_rdy",   32'(bus.KEY_RDY), 32'd0);
    tick();
    RST_N = 1'b1;
    tick();
    tick();
    chk("post_rst2_mux", 32'(bus.MUX_O), 32'd0);

`ifdef KEYED_MUX_KEY_PARITY_EN
    // 1101 has three ones, so parity bit 1 is correct and 0 is wrong.
    load_bits(8'b0001_1101, 5);
    tick();
    chk("par_ok_armed", 32'(bus.ARMED),   32'd1);
    chk("par_ok_err",   32'(bus.KEY_ERR), 32'd0);
    tick();
    chk("par_ok_mux",   32'(bus.MUX_O),   32'b11);
    load_bits(8'b0000_1101, 5);
    tick();
    chk("par_bad_err",   32'(bus.KEY_ERR), 32'd1);
    chk("par_bad_armed", 32'(bus.ARMED),   32'd0);
    tick();
    chk("par_bad_mux",   32'(bus.MUX_O),   32'd0);
    chk("par_bad_idle",  32'(bus.KEY_RDY), 32'd0);
    bus.KEY_START = 1'b1;
    tick();
    bus.KEY_START = 1'b0;
    chk("par_err_clr", 32'(bus.KEY_ERR), 32'd0);
`else
    chk("err_tied0", 32'(bus.KEY_ERR), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
